cci_dma_burst_rd: RTL and testbench

- Parametrised successor to the single-line DMA read path: one read descriptor of N cachelines, issued as aligned multi-line bursts (1/2/4 lines) with up to NUM_TAGS bursts outstanding.
- Accepts out-of-order responses tagged by burst and line number. Reorders them in a reorder buffer (ROB) and delivers a strictly in-order valid/ready stream to the DMA consumer.
- Sits between the FIU c0 channel adapter and the dma_if read side of the AFU.

---
 rtl/cci_dma_burst_rd_if.sv | 53 +++++
 rtl/cci_dma_burst_rd.sv | 223 ++++++++++++++++++++++
 tb/tb_cci_dma_burst_rd.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cci_dma_burst_rd_if.sv
`default_nettype none
// ============================================================================
// Module      : cci_dma_burst_rd_if
// Description : Bus bundle for the burst DMA read path. It carries the burst
//               request channel toward the FIU c0 adapter, the tagged
//               response channel coming back from it, and the in-order
//               valid/ready stream toward the DMA consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface cci_dma_burst_rd_if #(
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 512,
  parameter int NUM_TAGS   = 16
);
  localparam int TAG_W = $clog2(NUM_TAGS);

  // Burst request channel (registered in the read engine)
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_len;
  logic [TAG_W-1:0]      req_tag;
  logic                  req_almost_full;

  // Tagged response channel (one line per beat, any order)
  logic                  rsp_valid;
  logic [TAG_W-1:0]      rsp_tag;
  logic [1:0]            rsp_cl_num;
  logic [DATA_WIDTH-1:0] rsp_data;

  // In-order line stream to the consumer
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  // Read engine side
  modport master (
    output req_valid, req_addr, req_len, req_tag,
    input  req_almost_full,
    input  rsp_valid, rsp_tag, rsp_cl_num, rsp_data,
    output out_valid, out_data,
    input  out_ready
  );

  // Environment side: FIU adapter plus consumer
  modport slave (
    input  req_valid, req_addr, req_len, req_tag,
    output req_almost_full,
    output rsp_valid, rsp_tag, rsp_cl_num, rsp_data,
    input  out_valid, out_data,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/cci_dma_burst_rd.sv
`default_nettype none
// ============================================================================
// Module      : cci_dma_burst_rd
// Description : Multi-line burst DMA read engine. Splits one descriptor of N
//               cachelines into aligned 1/2/4-line bursts, keeps up to
//               NUM_TAGS bursts in flight, reorders the tagged responses in a
//               reorder buffer and emits a strictly in-order line stream.
// Revision    : 1.0 - initial release
// ============================================================================
module cci_dma_burst_rd #(
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 512,
  parameter int MAX_BURST  = 4,
  parameter int NUM_TAGS   = 16
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  go,
  input  wire logic [ADDR_WIDTH-1:0] start_addr,
  input  wire logic [ADDR_WIDTH:0]   size,
  output logic                       busy,
  output logic                       done,
  cci_dma_burst_rd_if.master         bus
);

  localparam int TAG_W  = $clog2(NUM_TAGS);
  localparam int DEPTH  = NUM_TAGS * MAX_BURST;
  localparam int SLOT_W = $clog2(DEPTH);
  localparam int CNT_W  = TAG_W + 1;

  localparam logic [ADDR_WIDTH:0] SZ_ZERO = '0;
  localparam logic [ADDR_WIDTH:0] SZ_ONE  = 1;
  localparam logic [ADDR_WIDTH:0] SZ_TWO  = 2;
  localparam logic [ADDR_WIDTH:0] SZ_FOUR = 4;
  localparam logic [CNT_W-1:0]    TAG_CAP = CNT_W'(NUM_TAGS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Control state
  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [TAG_W-1:0]      alloc_ptr;
  logic [CNT_W-1:0]      inflight;
  logic [1:0]            tag_len [NUM_TAGS];

  // Registered request outputs
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [1:0]            issue_len;
  logic [TAG_W-1:0]      issue_tag;

  // Reorder buffer and its drain pointer
  logic [DEPTH-1:0]      rob_valid;
  logic [DATA_WIDTH-1:0] rob_data [DEPTH];
  logic [TAG_W-1:0]      head_tag;
  logic [1:0]            head_cl;

  // Combinational helpers
  logic                  start;
  logic                  issue;
  logic [1:0]            burst_code;
  logic [ADDR_WIDTH:0]   burst_lines;
  logic [SLOT_W-1:0]     wr_idx;
  logic [SLOT_W-1:0]     head_idx;
  logic                  head_valid;
  logic                  fire;
  logic                  free_tag;

  assign start = (state == IDLE) && go && (size != SZ_ZERO);

  // Issue is gated only by tags: every outstanding line already owns a
  // reserved ROB slot, so the buffer cannot overflow.
  assign issue = (state == ISSUE) && !bus.req_almost_full && (inflight < TAG_CAP);

  // Pick the largest aligned burst that still fits in what is left to issue.
  always_comb begin
    burst_code  = 2'd0;
    burst_lines = SZ_ONE;
    if (MAX_BURST >= 4 && remaining >= SZ_FOUR && cur_addr[1:0] == 2'b00) begin
      burst_code  = 2'd3;
      burst_lines = SZ_FOUR;
    end else if (MAX_BURST >= 2 && remaining >= SZ_TWO && cur_addr[0] == 1'b0) begin
      burst_code  = 2'd1;
      burst_lines = SZ_TWO;
    end
  end

  // Slot layout is tag-major, so walking tags in allocation order walks
  // lines in address order.
  assign wr_idx   = SLOT_W'(bus.rsp_tag) * SLOT_W'(MAX_BURST) + SLOT_W'(bus.rsp_cl_num);
  assign head_idx = SLOT_W'(head_tag) * SLOT_W'(MAX_BURST) + SLOT_W'(head_cl);

  assign head_valid = rob_valid[head_idx];
  assign fire       = head_valid && bus.out_ready;
  // The last line of a burst releases its tag; skipping the unused slots of
  // a short burst falls out of jumping straight to the next tag.
  assign free_tag   = fire && (head_cl == tag_len[head_tag]);

  assign bus.out_valid = head_valid;
  assign bus.out_data  = rob_data[head_idx];

  assign bus.req_valid = issue_valid;
  assign bus.req_addr  = issue_addr;
  assign bus.req_len   = issue_len;
  assign bus.req_tag   = issue_tag;

  assign done = !busy;

  // Descriptor FSM: latches the descriptor, issues bursts and waits for drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      cur_addr    <= '0;
      remaining   <= '0;
      alloc_ptr   <= '0;
      issue_valid <= 1'b0;
      issue_addr  <= '0;
      issue_len   <= 2'd0;
      issue_tag   <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        tag_len[i] <= 2'd0;
      end
    end else begin
      issue_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            cur_addr  <= start_addr;
            remaining <= size;
            alloc_ptr <= '0;
          end
        end
        ISSUE: begin
          if (issue) begin
            issue_valid        <= 1'b1;
            issue_addr         <= cur_addr;
            issue_len          <= burst_code;
            issue_tag          <= alloc_ptr;
            tag_len[alloc_ptr] <= burst_code;
            alloc_ptr          <= alloc_ptr + TAG_W'(1);
            cur_addr           <= cur_addr + burst_lines[ADDR_WIDTH-1:0];
            remaining          <= remaining - burst_lines;
            if (remaining == burst_lines) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (inflight == '0 && rob_valid == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding-burst count: up on issue, down when a burst fully drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({issue, free_tag})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Drain pointer: next line within the burst, or first line of next tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_tag <= '0;
      head_cl  <= 2'd0;
    end else if (start) begin
      head_tag <= '0;
      head_cl  <= 2'd0;
    end else if (free_tag) begin
      head_tag <= head_tag + TAG_W'(1);
      head_cl  <= 2'd0;
    end else if (fire) begin
      head_cl  <= head_cl + 2'd1;
    end
  end

  // ROB valid bits: clear the slot leaving, set the slot arriving. They are
  // independent bits, so a response landing on the next head slot in the
  // same cycle the head advances is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rob_valid <= '0;
    end else begin
      if (fire) begin
        rob_valid[head_idx] <= 1'b0;
      end
      if (bus.rsp_valid) begin
        rob_valid[wr_idx] <= 1'b1;
      end
    end
  end

  // ROB data store; payload needs no reset because the valid bits guard it.
  always_ff @(posedge clk) begin
    if (bus.rsp_valid) begin
      rob_data[wr_idx] <= bus.rsp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cci_dma_burst_rd.sv
`default_nettype none
// ============================================================================
// Module      : tb_cci_dma_burst_rd
// Description : Directed self-checking bench for the burst DMA read engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cci_dma_burst_rd;

  localparam int AW = 42;
  localparam int DW = 64;
  localparam int MB = 4;
  localparam int NT = 4;
  localparam int TW = $clog2(NT);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          go;
  logic [AW-1:0] start_addr;
  logic [AW:0]   size;
  logic          busy;
  logic          done;

  cci_dma_burst_rd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TAGS(NT)) bus ();

  cci_dma_burst_rd #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .NUM_TAGS(NT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .start_addr(start_addr), .size(size),
    .busy(busy), .done(done), .bus(bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW-1:0] rq_addr [$];
  logic [1:0]    rq_len  [$];
  logic [TW-1:0] rq_tag  [$];
  logic [DW-1:0] oq      [$];

  // Expected line payload for a given cacheline address
  function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
    return {22'h15A5A5, a};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Record requests and transfers mid-cycle, clear of the active edge
  always @(negedge clk) begin
    if (rst_n && bus.req_valid) begin
      rq_addr.push_back(bus.req_addr);
      rq_len.push_back(bus.req_len);
      rq_tag.push_back(bus.req_tag);
    end
    if (rst_n && bus.out_valid && bus.out_ready) oq.push_back(bus.out_data);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_q();
    rq_addr.delete(); rq_len.delete(); rq_tag.delete(); oq.delete();
  endtask

  task automatic pulse_go(input logic [AW-1:0] a, input logic [AW:0] s);
    start_addr = a; size = s; go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic rsp(input int tag, input int cl, input logic [AW-1:0] a);
    bus.rsp_valid  = 1'b1;
    bus.rsp_tag    = TW'(tag);
    bus.rsp_cl_num = 2'(cl);
    bus.rsp_data   = dat(a);
    tick();
    bus.rsp_valid  = 1'b0;
  endtask

  task automatic rsp_burst(input int tag, input logic [AW-1:0] base, input int n, input bit rev);
    for (int i = 0; i < n; i++) begin
      int c;
      c = rev ? (n - 1 - i) : i;
      rsp(tag, c, base + AW'(c));
    end
  endtask

  task automatic exp_req(input int i, input logic [AW-1:0] a, input logic [1:0] l, input int t);
    if (i < rq_addr.size()) begin
      check("req_addr", DW'(rq_addr[i]), DW'(a));
      check("req_len", DW'(rq_len[i]), DW'(l));
      check("req_tag", DW'(rq_tag[i]), DW'(t));
    end else begin
      check("req_missing", DW'(rq_addr.size()), DW'(i + 1));
    end
  endtask

  task automatic exp_out(input logic [AW-1:0] base, input int n);
    check("out_count", DW'(oq.size()), DW'(n));
    for (int i = 0; i < n; i++) begin
      if (i < oq.size()) check("out_data", oq[i], dat(base + AW'(i)));
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    check("done_after_drain", DW'(done), DW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; go = 1'b0; start_addr = '0; size = '0;
    bus.req_almost_full = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_tag = '0;
    bus.rsp_cl_num = 2'd0; bus.rsp_data = '0; bus.out_ready = 1'b1;
    tick(3);
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(1));
    check("rst_req_valid", DW'(bus.req_valid), DW'(0));
    check("rst_out_valid", DW'(bus.out_valid), DW'(0));
    rst_n = 1'b1;
    tick(2);

    // Single line
    clear_q();
    pulse_go(42'h100, 1);
    check("t1_busy", DW'(busy), DW'(1));
    tick(4);
    check("t1_nreq", DW'(rq_addr.size()), DW'(1));
    exp_req(0, 42'h100, 2'd0, 0);
    rsp(0, 0, 42'h100);
    check("t1_out_valid_latency", DW'(bus.out_valid), DW'(1));
    check("t1_out_data", bus.out_data, dat(42'h100));
    wait_done(10);
    exp_out(42'h100, 1);

    // Unaligned start: 1 + 2 + 4 lines, responses out of order
    clear_q();
    pulse_go(42'h101, 7);
    tick(6);
    check("t2_nreq", DW'(rq_addr.size()), DW'(3));
    exp_req(0, 42'h101, 2'd0, 0);
    exp_req(1, 42'h102, 2'd1, 1);
    exp_req(2, 42'h104, 2'd3, 2);
    rsp_burst(2, 42'h104, 4, 1'b0);
    rsp_burst(1, 42'h102, 2, 1'b1);
    rsp_burst(0, 42'h101, 1, 1'b0);
    wait_done(20);
    exp_out(42'h101, 7);

    // 16 lines, fully reversed response order
    clear_q();
    pulse_go(42'h200, 16);
    tick(8);
    check("t3_nreq", DW'(rq_addr.size()), DW'(4));
    for (int t = 0; t < 4; t++) exp_req(t, 42'h200 + AW'(4 * t), 2'd3, t);
    for (int t = 3; t >= 0; t--) rsp_burst(t, 42'h200 + AW'(4 * t), 4, 1'b1);
    wait_done(30);
    exp_out(42'h200, 16);

    // Tag exhaustion then reuse of tag 0
    clear_q();
    pulse_go(42'h400, 20);
    tick(10);
    check("t4_nreq_capped", DW'(rq_addr.size()), DW'(4));
    check("t4_req_valid_idle", DW'(bus.req_valid), DW'(0));
    rsp_burst(0, 42'h400, 4, 1'b0);
    tick(5);
    check("t4_nreq_after_free", DW'(rq_addr.size()), DW'(5));
    exp_req(4, 42'h410, 2'd3, 0);
    for (int t = 1; t < 4; t++) rsp_burst(t, 42'h400 + AW'(4 * t), 4, 1'b0);
    rsp_burst(0, 42'h410, 4, 1'b1);
    wait_done(30);
    exp_out(42'h400, 20);

    // Consumer stall with almost-full toggling during issue
    clear_q();
    pulse_go(42'h500, 12);
    for (int k = 0; k < 40 && rq_addr.size() < 3; k++) begin
      bus.req_almost_full = ~bus.req_almost_full;
      tick();
    end
    bus.req_almost_full = 1'b0;
    tick(2);
    check("t5_nreq", DW'(rq_addr.size()), DW'(3));
    exp_req(1, 42'h504, 2'd3, 1);
    rsp_burst(0, 42'h500, 4, 1'b0);
    tick(2);
    bus.out_ready = 1'b0;
    rsp_burst(2, 42'h508, 4, 1'b1);
    rsp_burst(1, 42'h504, 4, 1'b0);
    for (int k = 0; k < 12; k++) begin
      check("t5_stall_valid", DW'(bus.out_valid), DW'(1));
      check("t5_stall_data", bus.out_data, dat(42'h504));
      tick();
    end
    check("t5_count_during_stall", DW'(oq.size()), DW'(4));
    bus.out_ready = 1'b1;
    wait_done(30);
    exp_out(42'h500, 12);

    // Asynchronous reset mid-transfer, then a fresh descriptor
    clear_q();
    bus.out_ready = 1'b0;
    pulse_go(42'h600, 8);
    tick(5);
    rsp(0, 0, 42'h600);
    check("t6_pre_rst_valid", DW'(bus.out_valid), DW'(1));
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", DW'(busy), DW'(0));
    check("t6_rst_done", DW'(done), DW'(1));
    check("t6_rst_req_valid", DW'(bus.req_valid), DW'(0));
    check("t6_rst_out_valid", DW'(bus.out_valid), DW'(0));
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    clear_q();
    pulse_go(42'h300, 2);
    tick(4);
    check("t6_nreq", DW'(rq_addr.size()), DW'(1));
    exp_req(0, 42'h300, 2'd1, 0);
    rsp_burst(0, 42'h300, 2, 1'b1);
    wait_done(10);
    exp_out(42'h300, 2);

    // go while busy is ignored; size 0 does nothing
    clear_q();
    pulse_go(42'h700, 8);
    pulse_go(42'h900, 4);
    tick(5);
    check("t7_nreq", DW'(rq_addr.size()), DW'(2));
    exp_req(0, 42'h700, 2'd3, 0);
    exp_req(1, 42'h704, 2'd3, 1);
    rsp_burst(1, 42'h704, 4, 1'b0);
    rsp_burst(0, 42'h700, 4, 1'b0);
    wait_done(20);
    exp_out(42'h700, 8);
    clear_q();
    pulse_go(42'h800, 0);
    check("t7_zero_busy", DW'(busy), DW'(0));
    check("t7_zero_done", DW'(done), DW'(1));
    tick(5);
    check("t7_zero_nreq", DW'(rq_addr.size()), DW'(0));
    check("t7_zero_nout", DW'(oq.size()), DW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
